instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 7 +
 rtl/pc_next.sv | 11 +
 rtl/instr_fetch.sv | 65 ++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/pc_next.sv
// pc_next: sequential or taken-branch next PC, always word aligned
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        take,
  input  logic [31:0] offset,
  output logic [31:0] npc
);
  assign npc = (pc + (take ? (offset & 32'hFFFF_FFFC) : PC_INC)) & 32'hFFFF_FFFC;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with hold register and timeout
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic [31:0] branch_offset_i,
  output logic        fetch_err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] RST_PC = RESET_PC & 32'hFFFF_FFFC;
  state_t state, state_n;
  logic [31:0] pc, npc;
  logic [CW-1:0] cnt, cnt_inc;
  pc_next u_pc_next (
    .pc    (pc),
    .take  (branch_i & zero_i),
    .offset(branch_offset_i),
    .npc   (npc)
  );
  assign cnt_inc = cnt + 1'b1;
  always_comb begin
    state_n = state == S_REQ  ? S_WAIT :
              state == S_WAIT ? (imem_rvalid_i ? S_HOLD : (cnt_inc == CW'(TIMEOUT) ? S_ERR : S_WAIT)) :
              state == S_HOLD ? (instr_ready_i ? S_REQ : S_HOLD) : S_ERR;
  end
  // request/valid are masked while reset is held so nothing leaks from a stale state
  assign imem_req_o    = state == S_REQ && !rst_i;
  assign instr_valid_o = state == S_HOLD && !rst_i;
  assign imem_addr_o   = pc;
  assign opcode_o      = instr_o[6:0];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_REQ;
      pc          <= RST_PC;
      pc_o        <= RST_PC;
      instr_o     <= NOP;
      cnt         <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_WAIT) cnt <= imem_rvalid_i ? '0 : cnt_inc;
      if (state == S_WAIT && imem_rvalid_i) begin
        instr_o <= imem_rdata_i;
        pc_o    <= pc;
      end
      if (state == S_HOLD && instr_ready_i) pc <= npc;
      if (state_n == S_ERR) fetch_err_o <= 1'b1;
    end
  end
endmodule
